// File: rtl/lemming_pkg.sv
// Shared state encoding and default sizing for the Lemming controller.
package lemming_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } lemming_state_t;

  localparam int SPLAT_LIMIT_DEF = 20;
  localparam int CNT_W_DEF       = 5;

endpackage

// File: rtl/lemming_ctrl_fall_counter.sv
// Saturating fall-length counter: synchronous clear beats enable, never wraps.
module fall_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/lemming_ctrl.sv
// Moore controller for one Lemming: walk, fall, dig, splat.
// Optional revive-from-SPLAT input is enabled by defining LEMMING_REVIVE_EN.
module lemming_ctrl
  import lemming_pkg::*;
#(
  parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic areset_n,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
`ifdef LEMMING_REVIVE_EN
  input  logic revive,
`endif
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic dead
);

  if ((2 ** CNT_W) - 1 < SPLAT_LIMIT) begin : g_cnt_w_chk
    $error("lemming_ctrl: CNT_W too narrow to reach SPLAT_LIMIT");
  end

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(SPLAT_LIMIT);

  lemming_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             falling;
  logic             splat_now;

  assign falling   = (state_q == FALL_L) || (state_q == FALL_R);
  // cnt counts completed fall cycles, so the landing cycle itself is not included
  assign splat_now = (cnt >= LIMIT_C);

  fall_counter #(
    .CNT_W (CNT_W)
  ) u_fall_counter (
    .clk      (clk),
    .areset_n (areset_n),
    .clr      (!falling),
    .en       (falling),
    .cnt      (cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WALK_L: begin
        if (!ground)        state_d = FALL_L;
        else if (dig)       state_d = DIG_L;
        else if (bump_left) state_d = WALK_R;
      end
      WALK_R: begin
        if (!ground)         state_d = FALL_R;
        else if (dig)        state_d = DIG_R;
        else if (bump_right) state_d = WALK_L;
      end
      FALL_L: if (ground) state_d = splat_now ? SPLAT : WALK_L;
      FALL_R: if (ground) state_d = splat_now ? SPLAT : WALK_R;
      DIG_L:  if (!ground) state_d = FALL_L;
      DIG_R:  if (!ground) state_d = FALL_R;
      SPLAT: begin
`ifdef LEMMING_REVIVE_EN
        if (revive) state_d = WALK_L;
`endif
      end
      default: state_d = WALK_L;
    endcase
  end

  always_comb begin
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    digging    = 1'b0;
    dead       = 1'b0;
    case (state_q)
      WALK_L:         walk_left  = 1'b1;
      WALK_R:         walk_right = 1'b1;
      FALL_L, FALL_R: aaah       = 1'b1;
      DIG_L, DIG_R:   digging    = 1'b1;
      SPLAT:          dead       = 1'b1;
      default:        walk_left  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= WALK_L;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_lemming_ctrl.sv
// Randomized and directed self-checking bench for lemming_ctrl against a behavioural model.
module tb_lemming_ctrl;

  localparam int SPLAT_LIMIT = 20;
  localparam int CNT_W       = 5;

  localparam int ACT_WALK = 0;
  localparam int ACT_FALL = 1;
  localparam int ACT_DIG  = 2;
  localparam int ACT_DEAD = 3;

  logic clk = 1'b0;
  logic areset_n;
  logic bump_left, bump_right, ground, dig;
  logic revive;
  logic walk_left, walk_right, aaah, digging, dead;
  logic [4:0] dut_out;

  int n_vec = 0;
  int n_err = 0;

  // Model: activity, facing direction (1 = right) and fall cycles including the current one
  int m_act;
  bit m_right;
  int m_fall_n;

  lemming_ctrl #(
    .SPLAT_LIMIT (SPLAT_LIMIT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .ground     (ground),
    .dig        (dig),
`ifdef LEMMING_REVIVE_EN
    .revive     (revive),
`endif
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  assign dut_out = {walk_left, walk_right, aaah, digging, dead};

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b (wl wr aaah dig dead), expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] mdl_out();
    case (m_act)
      ACT_WALK: return m_right ? 5'b01000 : 5'b10000;
      ACT_FALL: return 5'b00100;
      ACT_DIG:  return 5'b00010;
      default:  return 5'b00001;
    endcase
  endfunction

  task automatic mdl_reset();
    m_act    = ACT_WALK;
    m_right  = 1'b0;
    m_fall_n = 0;
  endtask

  task automatic mdl_step(input bit bl, input bit br, input bit g, input bit d, input bit rv);
    case (m_act)
      ACT_WALK: begin
        if (!g) begin
          m_act    = ACT_FALL;
          m_fall_n = 1;
        end else if (d) begin
          m_act = ACT_DIG;
        end else if (m_right ? br : bl) begin
          m_right = !m_right;
        end
      end
      ACT_FALL: begin
        if (!g) m_fall_n++;
        else if (m_fall_n > SPLAT_LIMIT) m_act = ACT_DEAD;
        else m_act = ACT_WALK;
      end
      ACT_DIG: begin
        if (!g) begin
          m_act    = ACT_FALL;
          m_fall_n = 1;
        end
      end
      default: begin
`ifdef LEMMING_REVIVE_EN
        if (rv) begin
          m_act   = ACT_WALK;
          m_right = 1'b0;
        end
`else
        if (rv) m_act = ACT_DEAD;
`endif
      end
    endcase
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string tag, input bit bl, input bit br, input bit g, input bit d,
                      input bit rv);
    bump_left  = bl;
    bump_right = br;
    ground     = g;
    dig        = d;
    revive     = rv;
    @(posedge clk);
    mdl_step(bl, br, g, d, rv);
    #1;
    chk(tag, dut_out, mdl_out());
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 1, 0, 0);
  endtask

  task automatic fall_then_land(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
    step(tag, 0, 0, 1, 0, 0);
  endtask

  // Asserts reset away from the clock edge and releases it at a falling edge.
  task automatic do_reset(input string tag);
    #2;
    areset_n   = 1'b0;
    bump_left  = 1'b0;
    bump_right = 1'b0;
    ground     = 1'b1;
    dig        = 1'b0;
    revive     = 1'b0;
    mdl_reset();
    #1;
    chk({tag, "_async"}, dut_out, 5'b10000);
    @(negedge clk);
    areset_n = 1'b1;
    #1;
    chk({tag, "_release"}, dut_out, 5'b10000);
  endtask

  initial begin
    int gnd_run;
    areset_n   = 1'b1;
    bump_left  = 1'b0;
    bump_right = 1'b0;
    ground     = 1'b1;
    dig        = 1'b0;
    revive     = 1'b0;
    mdl_reset();
    @(negedge clk);
    do_reset("por");
    idle("idle", 3);
    chk("idle_walk_left", dut_out, 5'b10000);

    step("bl_in_walkL", 1, 0, 1, 0, 0);
    chk("bl_turns_right", dut_out, 5'b01000);
    step("bl_in_walkR", 1, 0, 1, 0, 0);
    chk("bl_ignored_right", dut_out, 5'b01000);
    step("both_in_walkR", 1, 1, 1, 0, 0);
    chk("both_turn_left", dut_out, 5'b10000);

    step("to_right", 1, 0, 1, 0, 0);
    fall_then_land("safe_fall", 20);
    chk("safe_land", dut_out, 5'b01000);

    fall_then_land("splat_fall", 21);
    chk("splat_land", dut_out, 5'b00001);
    for (int i = 0; i < 10; i++)
      step("dead_hold", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    chk("dead_after_noise", dut_out, 5'b00001);
    do_reset("rst_dead");

    fall_then_land("sat_fall", 40);
    chk("sat_splat", dut_out, 5'b00001);
    do_reset("rst_sat");

    step("dig_start", 0, 0, 1, 1, 0);
    chk("dig_on", dut_out, 5'b00010);
    step("dig_bump", 0, 1, 1, 0, 0);
    chk("dig_bump_hold", dut_out, 5'b00010);
    step("dig_drop", 0, 0, 0, 0, 0);
    chk("dig_to_fall", dut_out, 5'b00100);
    step("dig_fall", 0, 0, 0, 0, 0);
    step("dig_fall", 0, 0, 0, 0, 0);
    step("dig_land", 0, 0, 1, 0, 0);
    chk("dig_land_left", dut_out, 5'b10000);

    step("prio", 1, 0, 0, 1, 0);
    chk("prio_fall", dut_out, 5'b00100);
    step("prio_land", 0, 0, 1, 0, 0);

`ifdef LEMMING_REVIVE_EN
    fall_then_land("rv_fall", 25);
    step("revive", 0, 0, 1, 0, 1);
    chk("revive_walk_left", dut_out, 5'b10000);
`endif

    gnd_run = 0;
    for (int i = 0; i < 1500; i++) begin
      bit g;
      if (gnd_run == 0 && $urandom_range(0, 9) == 0) gnd_run = $urandom_range(1, 35);
      g = (gnd_run == 0);
      if (gnd_run > 0) gnd_run--;
      if ($urandom_range(0, 99) == 0 || (m_act == ACT_DEAD && $urandom_range(0, 7) == 0)) begin
        do_reset("rnd_rst");
        gnd_run = 0;
      end else begin
        step("rnd", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), g,
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
